// File: rtl/baud_frac_gen.sv
// baud_frac_gen
//   Fractional baud / oversample tick generator. A down-counter reloaded with
//   the integer part of the divisor produces the oversample strobe. A
//   fractional accumulator stretches some periods by one cycle, so the
//   long-run period is div_current / 2^FRAC_BITS clock cycles. Every
//   OVERSAMPLE-th oversample strobe is also a bit strobe.
//
// Ports
//   clk_in        system clock
//   rst_in        asynchronous active-high reset
//   enable        run (1) / hold (0)
//   div_wr        one-cycle strobe that stages div_data
//   div_data      new divisor: integer part in the upper bits, FRAC_BITS fraction
//   rx_sync       one-cycle strobe that restarts the bit phase
//   rx_tick       oversample strobe, one cycle wide
//   tx_tick       bit strobe, one cycle wide, coincident with rx_tick at phase 0
//   sample_phase  oversample index of the most recent rx_tick
//   div_busy      a staged divisor is waiting to be applied
//   div_current   divisor currently in use
module baud_frac_gen #(
  parameter int CLOCK_RATE   = 100000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int FRAC_BITS    = 4,
  parameter int DIV_WIDTH    = 16,
  localparam int PH_W        = $clog2(OVERSAMPLE)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 enable,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_data,
  input  logic                 rx_sync,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic [PH_W-1:0]      sample_phase,
  output logic                 div_busy,
  output logic [DIV_WIDTH-1:0] div_current
);

  localparam int INT_W = DIV_WIDTH - FRAC_BITS;

  // Reset divisor, rounded to nearest, computed in 64 bits to avoid overflow.
  localparam logic [63:0] DEF_NUM = 64'(CLOCK_RATE) * (64'd1 << FRAC_BITS)
                                  + (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE)) / 64'd2;
  localparam logic [63:0] DEF_DEN = 64'(DEFAULT_BAUD) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_Q   = DEF_NUM / DEF_DEN;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DEF_Q[DIV_WIDTH-1:0];
  localparam logic [INT_W-1:0]     DEF_INT     = DEFAULT_DIV[DIV_WIDTH-1:FRAC_BITS];

  // A period shorter than two cycles cannot be represented by the counter
  // scheme, so the integer part is forced up to 2; the fraction is kept.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    logic [INT_W-1:0] ip;
    ip = d[DIV_WIDTH-1:FRAC_BITS];
    if (ip < INT_W'(2)) ip = INT_W'(2);
    return {ip, d[FRAC_BITS-1:0]};
  endfunction

  logic [INT_W-1:0]     cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic                 rx_tick_q, rx_tick_d;
  logic                 tx_tick_q, tx_tick_d;
  logic                 busy_q, busy_d;
  logic [DIV_WIDTH-1:0] cur_q, cur_d;
  logic [DIV_WIDTH-1:0] stage_q, stage_d;

  logic [INT_W-1:0]     cur_int;
  logic [INT_W-1:0]     stage_int;
  logic [FRAC_BITS-1:0] cur_frac;
  logic [FRAC_BITS:0]   acc_sum;
  logic [PH_W-1:0]      phase_inc;
  logic                 tick_ev;
  logic                 tx_ev;
  logic                 apply;

  assign cur_int   = cur_q[DIV_WIDTH-1:FRAC_BITS];
  assign cur_frac  = cur_q[FRAC_BITS-1:0];
  assign stage_int = stage_q[DIV_WIDTH-1:FRAC_BITS];
  assign acc_sum   = {1'b0, acc_q} + {1'b0, cur_frac};
  // OVERSAMPLE is a power of two, so the phase wraps naturally.
  assign phase_inc = phase_q + PH_W'(1);

  // A sync landing on a terminal count wins: the tick is suppressed.
  assign tick_ev = enable && (cnt_q == '0) && !rx_sync;
  assign tx_ev   = tick_ev && (phase_inc == '0);
  // Staged divisors take effect on a bit boundary, or at once while held.
  assign apply   = busy_q && (tx_ev || !enable);

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    rx_tick_d = 1'b0;
    tx_tick_d = 1'b0;
    busy_d    = busy_q;
    cur_d     = cur_q;
    stage_d   = stage_q;

    if (rx_sync) begin
      cnt_d   = cur_int - INT_W'(1);
      acc_d   = '0;
      phase_d = '0;
    end else if (enable) begin
      if (tick_ev) begin
        rx_tick_d = 1'b1;
        tx_tick_d = tx_ev;
        phase_d   = phase_inc;
        acc_d     = acc_sum[FRAC_BITS-1:0];
        // The accumulator carry stretches the next period by one cycle.
        cnt_d     = cur_int - INT_W'(1) + INT_W'(acc_sum[FRAC_BITS]);
      end else begin
        cnt_d = cnt_q - INT_W'(1);
      end
    end

    if (apply) begin
      cur_d = stage_q;
      acc_d = '0;
      // On a bit boundary the period that follows already uses the new rate;
      // while held, the remaining count is left untouched.
      if (tx_ev) cnt_d = stage_int - INT_W'(1);
    end

    // A write coinciding with an apply restages and keeps busy set.
    if (div_wr) begin
      stage_d = clamp_div(div_data);
      busy_d  = 1'b1;
    end else if (apply) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= DEF_INT - INT_W'(1);
      acc_q     <= '0;
      phase_q   <= '0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
      busy_q    <= 1'b0;
      cur_q     <= DEFAULT_DIV;
      stage_q   <= DEFAULT_DIV;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
      busy_q    <= busy_d;
      cur_q     <= cur_d;
      stage_q   <= stage_d;
    end
  end

  assign rx_tick      = rx_tick_q;
  assign tx_tick      = tx_tick_q;
  assign sample_phase = phase_q;
  assign div_busy     = busy_q;
  assign div_current  = cur_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Testbench for baud_frac_gen. A tick-level reference model pushes one
// expected record per rx_tick into a queue; a negedge monitor pops and
// compares each record when the DUT emits the tick.
module tb_baud_frac_gen;

  localparam int OS      = 16;
  localparam int FB      = 4;
  localparam int DW      = 16;
  localparam int DEF_DIV = 10417;

  logic          clk;
  logic          rst_in;
  logic          enable;
  logic          div_wr;
  logic [DW-1:0] div_data;
  logic          rx_sync;
  logic          rx_tick;
  logic          tx_tick;
  logic [3:0]    sample_phase;
  logic          div_busy;
  logic [DW-1:0] div_current;

  baud_frac_gen #(
    .CLOCK_RATE  (100000000),
    .DEFAULT_BAUD(9600),
    .OVERSAMPLE  (OS),
    .FRAC_BITS   (FB),
    .DIV_WIDTH   (DW)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .enable      (enable),
    .div_wr      (div_wr),
    .div_data    (div_data),
    .rx_sync     (rx_sync),
    .rx_tick     (rx_tick),
    .tx_tick     (tx_tick),
    .sample_phase(sample_phase),
    .div_busy    (div_busy),
    .div_current (div_current)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gap;
    int phase;
    int tx;
    int cur;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int last_cyc = 0;
  int last_tx  = 0;
  int tx_gap   = 0;

  // Reference model state (tick granularity).
  int m_gap, m_acc, m_phase, m_cur, m_stage, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int int_of(input int d);
    return d >> FB;
  endfunction

  function automatic int frac_of(input int d);
    return d & ((1 << FB) - 1);
  endfunction

  function automatic int clampd(input int d);
    if (int_of(d) < 2) return (2 << FB) | frac_of(d);
    return d;
  endfunction

  task automatic model_reset();
    m_gap   = int_of(DEF_DIV);
    m_acc   = 0;
    m_phase = 0;
    m_cur   = DEF_DIV;
    m_stage = DEF_DIV;
    m_busy  = 0;
  endtask

  // Predict the next n rx_ticks.
  task automatic exp_tick(input int n);
    exp_t e;
    int   sum;
    bit   applied;
    for (int k = 0; k < n; k++) begin
      m_phase = (m_phase + 1) % OS;
      applied = 1'b0;
      if (m_phase == 0 && m_busy != 0) begin
        m_cur   = m_stage;
        m_busy  = 0;
        applied = 1'b1;
      end
      e.gap   = m_gap;
      e.phase = m_phase;
      e.tx    = (m_phase == 0) ? 1 : 0;
      e.cur   = m_cur;
      e.busy  = m_busy;
      exp_q.push_back(e);
      if (applied) begin
        m_acc = 0;
        m_gap = int_of(m_cur);
      end else begin
        sum   = m_acc + frac_of(m_cur);
        m_acc = sum % (1 << FB);
        m_gap = int_of(m_cur) + sum / (1 << FB);
      end
    end
  endtask

  // Sync issued after w cycles past the last tick.
  task automatic model_sync(input int w);
    m_phase = 0;
    m_acc   = 0;
    m_gap   = w + 1 + int_of(m_cur);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst_in === 1'b1) begin
      last_cyc = cyc;
    end else if (rx_tick === 1'b1) begin
      g        = cyc - last_cyc;
      last_cyc = cyc;
      if (tx_tick === 1'b1) begin
        tx_gap  = cyc - last_tx;
        last_tx = cyc;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick_gap", g, e.gap);
        chk("tick_phase", sample_phase, e.phase);
        chk("tick_tx", tx_tick, e.tx);
        chk("tick_div", div_current, e.cur);
        chk("tick_busy", div_busy, e.busy);
      end
    end
  end

  initial begin
    int held;
    rst_in   = 1'b1;
    enable   = 1'b1;
    div_wr   = 1'b0;
    div_data = '0;
    rx_sync  = 1'b0;
    repeat (3) step();
    chk("rst_rx", rx_tick, 0);
    chk("rst_tx", tx_tick, 0);
    chk("rst_phase", sample_phase, 0);
    chk("rst_busy", div_busy, 0);
    chk("rst_div", div_current, DEF_DIV);
    rst_in = 1'b0;
    model_reset();

    // Default rate: 651 x15 then 652, bit period 10417.
    exp_tick(32);
    wait_drain(25000);
    chk("tx_gap_default", tx_gap, 10417);

    // Divisor 0x0040 staged mid-bit, applied at the next bit boundary.
    div_data = 16'h0040;
    div_wr   = 1'b1;
    m_stage  = clampd(16'h0040);
    m_busy   = 1;
    step();
    div_wr = 1'b0;
    chk("busy_wr40", div_busy, 1);
    exp_tick(32);
    wait_drain(12000);
    chk("tx_gap_div40", tx_gap, 64);

    // Divisor 0x0048: gaps alternate 4/5, bit period 72.
    div_data = 16'h0048;
    div_wr   = 1'b1;
    m_stage  = clampd(16'h0048);
    m_busy   = 1;
    step();
    div_wr = 1'b0;
    chk("busy_wr48", div_busy, 1);
    exp_tick(48);
    wait_drain(3000);
    chk("tx_gap_div48", tx_gap, 72);

    // Divisor 0x0010 written while held: clamped to 0x0020, applied next cycle.
    enable   = 1'b0;
    div_data = 16'h0010;
    div_wr   = 1'b1;
    step();
    div_wr = 1'b0;
    chk("busy_wr10", div_busy, 1);
    step();
    chk("busy_clear_hold", div_busy, 0);
    chk("div_clamped", div_current, 16'h0020);
    enable  = 1'b1;
    m_cur   = clampd(16'h0010);
    m_busy  = 0;
    m_acc   = 0;
    m_gap  += 2;
    exp_tick(16);
    wait_drain(500);

    // Divisor 0x0100 (I=16) written while held.
    enable   = 1'b0;
    div_data = 16'h0100;
    div_wr   = 1'b1;
    step();
    div_wr = 1'b0;
    step();
    chk("div_100", div_current, 16'h0100);
    enable  = 1'b1;
    m_cur   = 16'h0100;
    m_busy  = 0;
    m_acc   = 0;
    m_gap  += 2;
    exp_tick(16);
    wait_drain(1000);

    // Hold for 100 cycles mid-period.
    repeat (5) step();
    enable = 1'b0;
    held   = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (rx_tick !== 1'b0 || tx_tick !== 1'b0) held++;
    end
    enable = 1'b1;
    chk("hold_ticks", held, 0);
    chk("hold_phase", sample_phase, m_phase);
    m_gap += 100;
    exp_tick(2);
    wait_drain(500);

    // Sync mid-period.
    repeat (6) step();
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    chk("sync_phase", sample_phase, 0);
    chk("sync_rx", rx_tick, 0);
    model_sync(6);
    exp_tick(16);
    wait_drain(1000);

    // Sync on the terminal-count cycle suppresses that tick.
    repeat (15) step();
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    chk("sync_tick_rx", rx_tick, 0);
    chk("sync_tick_phase", sample_phase, 0);
    model_sync(15);
    exp_tick(1);
    wait_drain(500);

    // Reset mid-period with a staged divisor pending.
    div_data = 16'h0300;
    div_wr   = 1'b1;
    step();
    div_wr = 1'b0;
    chk("busy_wr300", div_busy, 1);
    step();
    step();
    rst_in = 1'b1;
    #1;
    chk("arst_rx", rx_tick, 0);
    chk("arst_tx", tx_tick, 0);
    chk("arst_phase", sample_phase, 0);
    chk("arst_busy", div_busy, 0);
    chk("arst_div", div_current, DEF_DIV);
    step();
    rst_in = 1'b0;
    model_reset();
    exp_tick(1);
    wait_drain(1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/baud_frac_gen.md
Name: baud_frac_gen

Overview:
Runtime-programmable fractional baud/oversample tick generator and successor to the fixed-rate Baud divider. It produces a single-cycle oversample strobe (rx_tick) and a bit-rate strobe (tx_tick) from one system clock, using a fixed-point divisor with a fractional accumulator. The UART receiver uses rx_tick, sample_phase and rx_sync for start-bit alignment; the transmitter uses tx_tick.

Parameters:
CLOCK_RATE, 100000000, system clock frequency in Hz.
DEFAULT_BAUD, 9600, baud rate loaded at reset.
OVERSAMPLE, 16, rx ticks per bit; must be a power of 2, at least 2.
FRAC_BITS, 4, fractional bits of the divisor.
DIV_WIDTH, 16, total divisor width (integer plus fraction); must exceed FRAC_BITS + 1.
Derived DEFAULT_DIV = (CLOCK_RATE*2^FRAC_BITS + DEFAULT_BAUD*OVERSAMPLE/2) / (DEFAULT_BAUD*OVERSAMPLE), rounded to nearest; 10417 with the defaults.
Derived PH_W = $clog2(OVERSAMPLE).

Ports:
clk_in  input  1  system clock; the only clock in the block.
rst_in  input  1  reset, asynchronous, active-high.
enable  input  1  run/hold control.
div_wr  input  1  one-cycle strobe that stages div_data.
div_data  input  DIV_WIDTH  new divisor: upper bits integer, low FRAC_BITS fraction.
rx_sync  input  1  one-cycle strobe that restarts the bit-phase.
rx_tick  output  1  oversample strobe, one cycle wide.
tx_tick  output  1  bit strobe, one cycle wide.
sample_phase  output  PH_W  oversample index of the most recent rx_tick.
div_busy  output  1  a staged divisor is pending.
div_current  output  DIV_WIDTH  divisor currently in use.

Behaviour:
- Reset (async assert, sync release): cnt = int(DEFAULT_DIV)-1, acc = 0, sample_phase = 0, rx_tick = 0, tx_tick = 0, div_busy = 0, div_current = DEFAULT_DIV, staged register = DEFAULT_DIV. All outputs are registered.
- Divisor split: I = div_current[DIV_WIDTH-1:FRAC_BITS], F = low FRAC_BITS bits.
- Clamp: a staged value with I < 2 is forced to I = 2 and keeps its F.
- Counting, only while enable = 1: cnt decrements each cycle.
- Tick event, at cnt == 0:
  - rx_tick = 1 on the next cycle.
  - {carry, acc} <= acc + F.
  - cnt <= I - 1 + carry.
  - sample_phase increments, wrapping OVERSAMPLE-1 -> 0.
  - tx_tick = 1 in the same cycle as the rx_tick whose sample_phase becomes 0.
- Period rule: the spacing between consecutive rx_ticks is I or I+1 cycles; the long-run average is div_current/2^FRAC_BITS.
- First tick: the first rx_tick after reset release with enable high appears I(DEFAULT) cycles later.
- enable = 0: cnt, acc and sample_phase hold; rx_tick and tx_tick stay 0. When re-enabled, counting resumes from the held cnt.
- Divisor handshake:
  - div_wr sets div_busy = 1 and latches div_data (clamped) into the staged register.
  - The staged value is applied at the next tx_tick event: div_current updates in the same cycle tx_tick is high, acc <= 0, the following period uses the new I, and div_busy clears.
  - If enable = 0, the staged value is applied the cycle after div_wr and div_busy clears then.
  - div_wr while busy overwrites the staged value; busy stays 1.
  - div_wr in the same cycle as a tx event: the old staged value is applied, the new value is staged, and busy stays 1.
- rx_sync, acting regardless of enable:
  - Next cycle: cnt <= I-1, acc <= 0, sample_phase <= 0, no tick.
  - If rx_sync coincides with a tick event, the sync wins and the tick is suppressed.
  - A pending divisor is not applied by a sync.
- Reset mid-operation: an in-flight tick is dropped and any staged divisor is discarded.

Test Plan:
- Defaults, enable = 1: rx_tick gaps are 651 cycles x15 then 652. tx_tick every 10417 cycles. sample_phase walks 1..15, 0. div_current = 10417.
- Write 0x0040 (I=4, F=0) mid-bit: div_busy = 1 until the next tx_tick. Afterwards rx_tick every 4 cycles and tx_tick every 64.
- Write 0x0048 (I=4, F=8): gaps alternate 4,5,4,5. tx_tick interval is 72 cycles.
- Write 0x0010 (I=1): div_current = 0x0020 and rx_tick every 2 cycles. With enable = 0 during the write, busy clears after 1 cycle.
- rx_sync mid-period, including on a tick cycle: that tick is suppressed, sample_phase = 0, the next rx_tick comes I cycles later, and tx_tick comes OVERSAMPLE ticks later.
- enable low for 100 cycles mid-period: no ticks, and the remaining gap resumes unchanged. rst_in pulse mid-period: all outputs return to reset values asynchronously.
